id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand bypass; directly upstream of the ALU.
//  - Captures decoded operands and control from ID.
//  - Drives ALU inputs a, b, alucont and sltunsigned, resolving RAW hazards from MEM and WB.
//  - Supports stall (hold) and flush (bubble) from the hazard unit.
// PARAMETERS
//  XLEN     32  datapath width
//  REGBITS   5  register-index width
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        synchronous, active-high
//  stall          in   1        hold EX contents
//  flush          in   1        insert bubble into EX
//  d_valid        in   1        ID holds a real instruction
//  d_rs1, d_rs2   in   REGBITS  source register indices
//  d_rd           in   REGBITS  destination register index
//  d_rs1data      in   XLEN     register-file read data, rs1
//  d_rs2data      in   XLEN     register-file read data, rs2
//  d_imm          in   XLEN     sign-extended immediate
//  d_alusrc       in   1        1: ALU b = imm
//  d_alucont      in   4        ALU op code
//  d_sltunsigned  in   1        unsigned compare select
//  d_regwrite     in   1        instruction writes rd
//  m_rd, m_regwrite, m_result   in  REGBITS/1/XLEN  EX/MEM producer
//  w_rd, w_regwrite, w_result   in  REGBITS/1/XLEN  MEM/WB producer
//  e_valid        out  1        EX holds a real instruction
//  e_a, e_b       out  XLEN     ALU operands
//  e_storedata    out  XLEN     forwarded rs2 value, for stores
//  e_alucont      out  4        registered d_alucont
//  e_sltunsigned  out  1        registered d_sltunsigned
//  e_rd           out  REGBITS  registered d_rd
//  e_regwrite     out  1        d_regwrite & valid
// BEHAVIOUR
//  - Reset: every register clears to 0, so all outputs read 0; e_a/e_b = 0 because rs=x0.
//  - Update priority per clk edge: reset > flush > stall > load.
//    - Flush: e_valid = 0, e_regwrite = 0, e_rd = 0, rs1/rs2 = 0; data fields don't-care.
//    - Stall: control fields hold. Stored rs1/rs2 data reload with their forwarded values,
//      so a producer retiring from WB during the stall is not lost.
//    - Load: all fields take d_*; e_regwrite = d_regwrite & d_valid.
//  - Bypass (combinational on registered indices), computed separately for rs1 and rs2:
//    - Use m_result if m_regwrite & m_rd == rs & rs != 0.
//    - Otherwise use w_result if w_regwrite & w_rd == rs & rs != 0.
//    - Otherwise use the stored data. MEM beats WB when both match.
//  - Operand mapping:
//    - e_a = fwd(rs1).
//    - e_b = alusrc ? imm : fwd(rs2).
//    - e_storedata = fwd(rs2) regardless of alusrc.
//  - Latency: 1 cycle ID -> EX; bypass adds 0 cycles.
//  - Load-use hazards are not detected here; the hazard unit must stall.
//  - Reset mid-stall or mid-flush: reset wins and the stage is empty next cycle.
// CONFIGURATION
//  - ID_EX_BYPASS_EN defined: bypass network as above.
//  - ID_EX_BYPASS_EN undefined:
//    - fwd(rs) = stored data and m_*/w_* are ignored.
//    - Stall holds data unchanged.
//    - The hazard unit must stall every RAW dependency until writeback.
// TESTING
//  1. reset=1 for 2 cycles, then d_valid=1 with random inputs
//     -> e_* all 0 until the first post-reset edge.
//  2. Load rs1=3, rs1data=5; m_rd=3, m_regwrite=1, m_result=0x10; w_rd=3, w_result=0x20
//     -> e_a=0x10 (MEM priority).
//  3. rs2=0; m_rd=0, m_regwrite=1, m_result=0xFF; stored rs2data=0
//     -> e_storedata=0 (x0 never forwarded).
//  4. stall=1 for 2 cycles; w_rd=rs1, w_result=0xABCD in cycle 1 only
//     -> e_a=0xABCD in both cycles; e_valid and e_alucont held.
//  5. flush=1 with stall=1, d_valid=1, d_regwrite=1
//     -> next cycle e_valid=0, e_regwrite=0, e_rd=0.
//  6. d_alusrc=1, d_imm=0xFFFFFFFC, rs2 forwarded 7
//     -> e_b=0xFFFFFFFC, e_storedata=7.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand bypass from MEM and WB.
// Optional feature: define ID_EX_BYPASS_EN to enable the forwarding network.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               d_valid,
    input  logic [REGBITS-1:0] d_rs1,
    input  logic [REGBITS-1:0] d_rs2,
    input  logic [REGBITS-1:0] d_rd,
    input  logic [XLEN-1:0]    d_rs1data,
    input  logic [XLEN-1:0]    d_rs2data,
    input  logic [XLEN-1:0]    d_imm,
    input  logic               d_alusrc,
    input  logic [3:0]         d_alucont,
    input  logic               d_sltunsigned,
    input  logic               d_regwrite,
    input  logic [REGBITS-1:0] m_rd,
    input  logic               m_regwrite,
    input  logic [XLEN-1:0]    m_result,
    input  logic [REGBITS-1:0] w_rd,
    input  logic               w_regwrite,
    input  logic [XLEN-1:0]    w_result,
    output logic               e_valid,
    output logic [XLEN-1:0]    e_a,
    output logic [XLEN-1:0]    e_b,
    output logic [XLEN-1:0]    e_storedata,
    output logic [3:0]         e_alucont,
    output logic               e_sltunsigned,
    output logic [REGBITS-1:0] e_rd,
    output logic               e_regwrite
);

    logic               valid_r;
    logic [REGBITS-1:0] rs1_r;
    logic [REGBITS-1:0] rs2_r;
    logic [REGBITS-1:0] rd_r;
    logic [XLEN-1:0]    rs1data_r;
    logic [XLEN-1:0]    rs2data_r;
    logic [XLEN-1:0]    imm_r;
    logic               alusrc_r;
    logic [3:0]         alucont_r;
    logic               sltunsigned_r;
    logic               regwrite_r;
    logic [XLEN-1:0]    fwd_a_s;
    logic [XLEN-1:0]    fwd_b_s;

`ifdef ID_EX_BYPASS_EN
    // MEM is the younger producer, so it is checked before WB; x0 is never forwarded.
    function automatic logic [XLEN-1:0] fwd(
        input logic [REGBITS-1:0] rs,
        input logic [XLEN-1:0]    stored,
        input logic [REGBITS-1:0] mrd,
        input logic               mwe,
        input logic [XLEN-1:0]    mres,
        input logic [REGBITS-1:0] wrd,
        input logic               wwe,
        input logic [XLEN-1:0]    wres
    );
        logic [XLEN-1:0] val;
        if (mwe && (mrd == rs) && (rs != {REGBITS{1'b0}})) begin
            val = mres;
        end else if (wwe && (wrd == rs) && (rs != {REGBITS{1'b0}})) begin
            val = wres;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Operand selection through the bypass network
    always_comb begin
        fwd_a_s = fwd(rs1_r, rs1data_r, m_rd, m_regwrite, m_result, w_rd, w_regwrite, w_result);
        fwd_b_s = fwd(rs2_r, rs2data_r, m_rd, m_regwrite, m_result, w_rd, w_regwrite, w_result);
    end
`else
    logic unused_s;
    assign unused_s = ^{m_rd, m_regwrite, m_result, w_rd, w_regwrite, w_result};

    // Without bypass the stored register-file data is used directly
    always_comb begin
        fwd_a_s = rs1data_r;
        fwd_b_s = rs2data_r;
    end
`endif

    // Pipeline register update: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_r       <= 1'b0;
            rs1_r         <= {REGBITS{1'b0}};
            rs2_r         <= {REGBITS{1'b0}};
            rd_r          <= {REGBITS{1'b0}};
            rs1data_r     <= {XLEN{1'b0}};
            rs2data_r     <= {XLEN{1'b0}};
            imm_r         <= {XLEN{1'b0}};
            alusrc_r      <= 1'b0;
            alucont_r     <= 4'h0;
            sltunsigned_r <= 1'b0;
            regwrite_r    <= 1'b0;
        end else if (stall) begin
            // Capture forwarded values so a producer retiring during the stall is kept
            rs1data_r <= fwd_a_s;
            rs2data_r <= fwd_b_s;
        end else begin
            valid_r       <= d_valid;
            rs1_r         <= d_rs1;
            rs2_r         <= d_rs2;
            rd_r          <= d_rd;
            rs1data_r     <= d_rs1data;
            rs2data_r     <= d_rs2data;
            imm_r         <= d_imm;
            alusrc_r      <= d_alusrc;
            alucont_r     <= d_alucont;
            sltunsigned_r <= d_sltunsigned;
            regwrite_r    <= d_regwrite & d_valid;
        end
    end

    // ALU operand and control outputs
    always_comb begin
        e_valid       = valid_r;
        e_a           = fwd_a_s;
        e_b           = alusrc_r ? imm_r : fwd_b_s;
        e_storedata   = fwd_b_s;
        e_alucont     = alucont_r;
        e_sltunsigned = sltunsigned_r;
        e_rd          = rd_r;
        e_regwrite    = regwrite_r;
    end

endmodule
